panel_cursor_grid: RTL

- Keyboard-driven cursor for the front-panel switch display, generalised to an N-row grid with per-row lengths.
- Decodes PS/2 arrow keys into cursor moves and keys 0/1/2 into switch actions.
- New relative to the fixed two-row cursor:
  - parametrised geometry;
  - up/down row stepping with column clamping;
  - Home key;
  - per-index latched/momentary selection;
  - internal arrow auto-repeat.
- Sits between the ps2_key bus and the panel renderer / switch register bank.

---
 rtl/panel_cursor_grid.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/panel_cursor_grid.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : panel_cursor_grid                                             |
// | Purpose  : Keyboard-driven cursor over an N-row front-panel switch grid. |
// |            Decodes PS/2 arrow/Home keys into cursor moves (with internal |
// |            auto-repeat) and keys 0/1/2 into switch actions.              |
// | Ports    : clk, reset          - clock, synchronous active-high reset    |
// |            ps2_key[10:0]       - [7:0] code, [8] ext, [9] make, [10] tog |
// |            cursor_index        - linear index (row base + column)        |
// |            cursor_row/col      - current row / column                    |
// |            cursor_action       - 00 off, 01 on, 10 momentary, 11 moved   |
// |            move_strobe         - one-cycle pulse per cursor move         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module panel_cursor_grid #(
    parameter int                    NUM_ROWS        = 2,
    parameter logic [5*NUM_ROWS-1:0] ROW_LEN         = {5'd9, 5'd16},
    parameter int                    IDX_W           = 5,
    parameter int                    MOMENTARY_FIRST = 18,
    parameter logic [31:0]           LATCHED_MASK    = 32'h0180_0000,
    parameter logic [23:0]           REPEAT_DELAY    = 24'd12_000_000,
    parameter logic [23:0]           REPEAT_RATE     = 24'd2_500_000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      ps2_key,
    output logic [IDX_W-1:0] cursor_index,
    output logic [1:0]       cursor_row,
    output logic [3:0]       cursor_col,
    output logic [1:0]       cursor_action,
    output logic             move_strobe
);

    localparam logic [7:0] c_key_right = 8'h74;
    localparam logic [7:0] c_key_left  = 8'h6B;
    localparam logic [7:0] c_key_up    = 8'h75;
    localparam logic [7:0] c_key_down  = 8'h72;
    localparam logic [7:0] c_key_home  = 8'h6C;
    localparam logic [7:0] c_key_0     = 8'h45;
    localparam logic [7:0] c_key_1     = 8'h16;
    localparam logic [7:0] c_key_2     = 8'h1E;

    localparam logic [1:0]       c_last_row  = 2'(NUM_ROWS - 1);
    localparam logic [IDX_W-1:0] c_mom_first = IDX_W'(MOMENTARY_FIRST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    // Rows beyond NUM_ROWS are unreachable; give them length 1 so the
    // lookup tables are fully defined.
    function automatic int f_len(input int r);
        if (r < NUM_ROWS) return int'(ROW_LEN[5*r +: 5]);
        return 1;
    endfunction

    function automatic int f_base(input int r);
        int s;
        s = 0;
        for (int i = 0; i < r; i++) s += f_len(i);
        return s;
    endfunction

    function automatic logic f_is_arrow(input logic [7:0] code);
        return (code == c_key_right) || (code == c_key_left) ||
               (code == c_key_up)    || (code == c_key_down);
    endfunction

    logic [4:0]       w_len  [4];
    logic [IDX_W-1:0] w_base [4];

    for (genvar g = 0; g < 4; g++) begin : g_rows
        localparam int c_len  = f_len(g);
        localparam int c_base = f_base(g);
        assign w_len[g]  = 5'(c_len);
        assign w_base[g] = IDX_W'(c_base);
    end

    logic             r_toggle;
    logic [1:0]       r_row, w_row;
    logic [3:0]       r_col, w_col;
    logic [IDX_W-1:0] r_index, w_index;
    logic [1:0]       r_action, w_action;
    logic             r_strobe, w_strobe;
    state_t           r_state, w_state;
    logic [7:0]       r_held, w_held;
    logic [23:0]      r_cnt, w_cnt;

    logic       w_event;
    logic       w_make;
    logic [7:0] w_code;
    logic       w_mom;
    logic       w_mv;
    logic [7:0] w_mv_code;
    logic       w_unused_ext;

    assign w_event      = ps2_key[10] != r_toggle;
    assign w_make       = ps2_key[9];
    assign w_code       = ps2_key[7:0];
    assign w_unused_ext = ps2_key[8];
    assign w_mom        = r_index >= c_mom_first;

    always_comb begin
        w_row     = r_row;
        w_col     = r_col;
        w_action  = r_action;
        w_strobe  = 1'b0;
        w_state   = r_state;
        w_held    = r_held;
        w_cnt     = r_cnt;
        w_mv      = 1'b0;
        w_mv_code = r_held;

        if (w_event) begin
            // Events that do not restart the timer let it keep running, but
            // an expiry coinciding with an event is held off until the next
            // event-free cycle.
            if (r_cnt != 24'd0) w_cnt = r_cnt - 24'd1;
            if (w_make) begin
                if (f_is_arrow(w_code)) begin
                    // Keyboard typematic of the held arrow is ignored.
                    if (!(r_state != S_IDLE && w_code == r_held)) begin
                        w_mv      = 1'b1;
                        w_mv_code = w_code;
                        w_held    = w_code;
                        if (REPEAT_DELAY != 24'd0) begin
                            w_state = S_DELAY;
                            w_cnt   = REPEAT_DELAY - 24'd1;
                        end else begin
                            w_state = S_IDLE;
                        end
                    end
                end else begin
                    case (w_code)
                        c_key_home: begin
                            w_mv      = 1'b1;
                            w_mv_code = c_key_home;
                            w_state   = S_IDLE;
                        end
                        c_key_0: begin
                            w_action = 2'b00;
                            w_state  = S_IDLE;
                        end
                        c_key_1: begin
                            w_action = 2'b01;
                            w_state  = S_IDLE;
                        end
                        c_key_2: begin
                            w_action = w_mom ? 2'b10 : 2'b00;
                            w_state  = S_IDLE;
                        end
                        default: ;
                    endcase
                end
            end else begin
                if ((w_code == c_key_1 || w_code == c_key_2) &&
                    w_mom && !LATCHED_MASK[r_index])
                    w_action = 2'b00;
                if (r_state != S_IDLE && w_code == r_held)
                    w_state = S_IDLE;
            end
        end else if (r_state != S_IDLE) begin
            if (r_cnt == 24'd0) begin
                w_mv    = 1'b1;
                w_cnt   = REPEAT_RATE - 24'd1;
                w_state = S_REPEAT;
            end else begin
                w_cnt = r_cnt - 24'd1;
            end
        end

        if (w_mv) begin
            w_action = 2'b11;
            w_strobe = 1'b1;
            case (w_mv_code)
                c_key_right: w_col = ({1'b0, r_col} + 5'd1 >= w_len[r_row]) ? 4'd0 : r_col + 4'd1;
                c_key_left:  w_col = (r_col == 4'd0) ? 4'(w_len[r_row] - 5'd1) : r_col - 4'd1;
                c_key_up:    w_row = (r_row == 2'd0) ? 2'd0 : r_row - 2'd1;
                c_key_down:  w_row = (r_row >= c_last_row) ? c_last_row : r_row + 2'd1;
                default: begin
                    w_row = 2'd0;
                    w_col = 4'd0;
                end
            endcase
            // Vertical moves keep the column but clamp it into the new row.
            if ((w_mv_code == c_key_up || w_mv_code == c_key_down) &&
                ({1'b0, r_col} > w_len[w_row] - 5'd1))
                w_col = 4'(w_len[w_row] - 5'd1);
        end

        w_index = w_base[w_row] + IDX_W'(w_col);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_toggle <= ps2_key[10];
            r_row    <= 2'd0;
            r_col    <= 4'd0;
            r_index  <= '0;
            r_action <= 2'b00;
            r_strobe <= 1'b0;
            r_state  <= S_IDLE;
            r_held   <= 8'd0;
            r_cnt    <= 24'd0;
        end else begin
            r_toggle <= ps2_key[10];
            r_row    <= w_row;
            r_col    <= w_col;
            r_index  <= w_index;
            r_action <= w_action;
            r_strobe <= w_strobe;
            r_state  <= w_state;
            r_held   <= w_held;
            r_cnt    <= w_cnt;
        end
    end

    assign cursor_index  = r_index;
    assign cursor_row    = r_row;
    assign cursor_col    = r_col;
    assign cursor_action = r_action;
    assign move_strobe   = r_strobe;

endmodule
`default_nettype wire
